serial_add_sequencer: RTL

SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

---
 rtl/serial_add_sequencer_pkg.sv | 20 ++
 rtl/serial_add_sequencer_nibble_shift_reg.sv | 32 +++
 rtl/serial_add_sequencer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/serial_add_sequencer_pkg.sv
// Shared types and constants for the nibble-serial add sequencer.
// The counter width helper keeps a 1-bit counter legal for single-nibble builds.
package serial_add_sequencer_pkg;

  localparam int NIBBLE_W        = 4;
  localparam int DEFAULT_NIBBLES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_NIBBLES);

endpackage

// File: rtl/serial_add_sequencer_nibble_shift_reg.sv
// Operand holding register that presents its least-significant nibble and
// shifts right by one nibble per step, zero-filling from the top.
module nibble_shift_reg
  import serial_add_sequencer_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                shift,
  input  logic [W-1:0]        d,
  output logic [NIBBLE_W-1:0] nib
);

  logic [W-1:0] q;

  // NOTE: clocked state is written with <= so every flop samples pre-edge
  // values; blocking assignments here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift) begin
      q <= q >> NIBBLE_W;
    end
  end

  assign nib = q[NIBBLE_W-1:0];

endmodule

// File: rtl/serial_add_sequencer.sv
// Sequences a W-bit addition through an external 4-bit adder, one nibble per
// cycle, least-significant first, and publishes the sum on a one-cycle done.
module serial_add_sequencer
  import serial_add_sequencer_pkg::*;
#(
  parameter int NIBBLES = DEFAULT_NIBBLES,
  localparam int W      = NIBBLE_W * NIBBLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [W-1:0]        op_a,
  input  logic [W-1:0]        op_b,
  input  logic                carry_in,
  output logic [NIBBLE_W-1:0] add_a,
  output logic [NIBBLE_W-1:0] add_b,
  output logic                add_cin,
  input  logic [NIBBLE_W-1:0] add_s,
  input  logic                add_cout,
  output logic                busy,
  output logic                done,
  output logic [W-1:0]        result,
  output logic                carry_out
);

  localparam int CW = cnt_width(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  state_e state_q, state_d;
  logic   load, step, last;

  logic [CW-1:0]                      cnt_q;
  logic                               carry_q;
  logic [NIBBLES-1:0][NIBBLE_W-1:0]   acc_q, acc_d;
  logic [W-1:0]                       result_q;
  logic                               carry_out_q;
  logic                               busy_q, done_q;
  logic [NIBBLE_W-1:0]                nib_a, nib_b;

  nibble_shift_reg #(.W(W)) u_shift_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (step),
    .d     (op_a),
    .nib   (nib_a)
  );

  nibble_shift_reg #(.W(W)) u_shift_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (step),
    .d     (op_b),
    .nib   (nib_b)
  );

  assign last = (cnt_q == LAST);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        load    = start;
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Accumulator image with the current adder nibble dropped into its slot;
  // on the final step this is exactly the value published to result.
  always_comb begin
    acc_d        = acc_q;
    acc_d[cnt_q] = add_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
    end else if (load) begin
      cnt_q   <= '0;
      carry_q <= carry_in;
    end else if (step) begin
      acc_q   <= acc_d;
      carry_q <= add_cout;
      cnt_q   <= cnt_q + CW'(1);
      if (last) begin
        result_q    <= acc_d;
        carry_out_q <= add_cout;
      end
    end
  end

  // The adder sees zeros whenever no nibble is in flight.
  assign add_a     = busy_q ? nib_a   : '0;
  assign add_b     = busy_q ? nib_b   : '0;
  assign add_cin   = busy_q ? carry_q : 1'b0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;

endmodule
